// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes and address-width derivation
// used by the register slave and the upstream write/read handlers.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Default bus geometry
  localparam int AXIL_DATA_WIDTH  = 32;
  localparam int AXIL_ADDR_WIDTH  = 5;
  localparam int AXIL_STRB_WIDTH  = AXIL_DATA_WIDTH / 8;
  localparam int AXIL_OFFSET_BITS = $clog2(AXIL_STRB_WIDTH);
  localparam int AXIL_INDEX_WIDTH = AXIL_ADDR_WIDTH - AXIL_OFFSET_BITS;

  // Number of byte-offset bits below the word index
  function automatic int offset_bits(input int strb_width);
    return $clog2(strb_width);
  endfunction

  // Width of the word index carved out of a byte address
  function automatic int index_width(input int addr_width, input int strb_width);
    return addr_width - offset_bits(strb_width);
  endfunction

endpackage

// File: rtl/axil_hold_reg.sv
// One-entry valid/ready holding register. Accepts a beat whenever empty,
// keeps it until the consumer pulses clear.
module axil_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] held_data,
  output logic             held,
  input  logic             clear
);

  assign in_ready = !held;

  // Capture a beat when empty; drop it when the consumer clears the entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held      <= 1'b0;
      held_data <= '0;
    end else if (in_valid && !held) begin
      held      <= 1'b1;
      held_data <= in_data;
    end else if (clear) begin
      held      <= 1'b0;
    end
  end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register-file slave: independent AW/W capture, write fire into a
// small word array with byte strobes, single-cycle read path, SLVERR for
// indices beyond the implemented registers.
module axil_reg_slave
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_REGS   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready
);

  localparam int OFF_BITS = offset_bits(STRB_WIDTH);
  localparam int IDX_W    = index_width(ADDR_WIDTH, STRB_WIDTH);
  localparam int W_BUNDLE = DATA_WIDTH + STRB_WIDTH;
  localparam logic [IDX_W:0] NUM_REGS_L = (IDX_W + 1)'(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [IDX_W-1:0]      aw_idx;
  logic                  aw_held;
  logic [W_BUNDLE-1:0]   w_bundle;
  logic                  w_held;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  write_fire;
  logic                  aw_in_range;

  logic [IDX_W-1:0]      ar_idx;
  logic                  ar_in_range;
  logic                  ar_fire;
  logic [DATA_WIDTH-1:0] rd_word;

  // Protection bits and byte-offset address bits carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{s_axil_awprot, s_axil_arprot,
                         s_axil_awaddr[OFF_BITS-1:0], s_axil_araddr[OFF_BITS-1:0]};

  axil_hold_reg #(.WIDTH(IDX_W)) u_aw_hold (
    .clk       (clk),
    .rst       (rst),
    .in_data   (s_axil_awaddr[ADDR_WIDTH-1:OFF_BITS]),
    .in_valid  (s_axil_awvalid),
    .in_ready  (s_axil_awready),
    .held_data (aw_idx),
    .held      (aw_held),
    .clear     (write_fire)
  );

  axil_hold_reg #(.WIDTH(W_BUNDLE)) u_w_hold (
    .clk       (clk),
    .rst       (rst),
    .in_data   ({s_axil_wdata, s_axil_wstrb}),
    .in_valid  (s_axil_wvalid),
    .in_ready  (s_axil_wready),
    .held_data (w_bundle),
    .held      (w_held),
    .clear     (write_fire)
  );

  assign w_data      = w_bundle[W_BUNDLE-1:STRB_WIDTH];
  assign w_strb      = w_bundle[STRB_WIDTH-1:0];
  assign write_fire  = aw_held && w_held && (!s_axil_bvalid || s_axil_bready);
  assign aw_in_range = {1'b0, aw_idx} < NUM_REGS_L;

  assign ar_idx         = s_axil_araddr[ADDR_WIDTH-1:OFF_BITS];
  assign ar_in_range    = {1'b0, ar_idx} < NUM_REGS_L;
  assign s_axil_arready = !s_axil_rvalid || s_axil_rready;
  assign ar_fire        = s_axil_arvalid && s_axil_arready;

  // Merge strobed bytes into the addressed word; out-of-range writes are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_fire && aw_in_range) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (aw_idx == IDX_W'(i)) begin
          for (int b = 0; b < STRB_WIDTH; b++) begin
            if (w_strb[b]) begin
              regs[i][8*b +: 8] <= w_data[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // Write response: a new fire overrides the drain of the previous one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= RESP_OKAY;
    end else if (write_fire) begin
      s_axil_bvalid <= 1'b1;
      s_axil_bresp  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (s_axil_bready) begin
      s_axil_bvalid <= 1'b0;
    end
  end

  // Read-side word lookup; unimplemented indices read as zero
  always_comb begin
    rd_word = '0;
    if (ar_in_range) begin
      rd_word = regs[ar_idx];
    end
  end

  // Read response register: loads on AR handshake, holds while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= '0;
      s_axil_rresp  <= RESP_OKAY;
    end else if (ar_fire) begin
      s_axil_rvalid <= 1'b1;
      s_axil_rdata  <= rd_word;
      s_axil_rresp  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (s_axil_rready) begin
      s_axil_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Self-checking bench for axil_reg_slave: directed scenarios plus randomized
// traffic compared against an array-based register model.
module tb_axil_reg_slave;

  localparam int NREG = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  s_axil_awaddr;
  logic [2:0]  s_axil_awprot;
  logic        s_axil_awvalid;
  logic        s_axil_awready;
  logic [31:0] s_axil_wdata;
  logic [3:0]  s_axil_wstrb;
  logic        s_axil_wvalid;
  logic        s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid;
  logic        s_axil_bready;
  logic [4:0]  s_axil_araddr;
  logic [2:0]  s_axil_arprot;
  logic        s_axil_arvalid;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_regs [NREG];

  axil_reg_slave dut (
    .clk            (clk),
    .rst            (rst),
    .s_axil_awaddr  (s_axil_awaddr),
    .s_axil_awprot  (s_axil_awprot),
    .s_axil_awvalid (s_axil_awvalid),
    .s_axil_awready (s_axil_awready),
    .s_axil_wdata   (s_axil_wdata),
    .s_axil_wstrb   (s_axil_wstrb),
    .s_axil_wvalid  (s_axil_wvalid),
    .s_axil_wready  (s_axil_wready),
    .s_axil_bresp   (s_axil_bresp),
    .s_axil_bvalid  (s_axil_bvalid),
    .s_axil_bready  (s_axil_bready),
    .s_axil_araddr  (s_axil_araddr),
    .s_axil_arprot  (s_axil_arprot),
    .s_axil_arvalid (s_axil_arvalid),
    .s_axil_arready (s_axil_arready),
    .s_axil_rdata   (s_axil_rdata),
    .s_axil_rresp   (s_axil_rresp),
    .s_axil_rvalid  (s_axil_rvalid),
    .s_axil_rready  (s_axil_rready)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Safety net in case a handshake never completes
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [4:0] addr);
    int idx = int'(addr) / 4;
    return (idx < NREG) ? model_regs[idx] : 32'd0;
  endfunction

  function automatic logic [1:0] modelResp(input logic [4:0] addr);
    int idx = int'(addr) / 4;
    return (idx < NREG) ? 2'b00 : 2'b10;
  endfunction

  task automatic modelWrite(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx = int'(addr) / 4;
    if (idx < NREG) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model_regs[idx][8*b +: 8] = data[8*b +: 8];
      end
    end
  endtask

  // Full write transaction: W presented at once, AW after aw_delay cycles
  task automatic writeTxn(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_delay, input string tag);
    int cyc, last;
    bit aw_done, w_done, a_hs, w_hs;
    logic [1:0] exp_resp;
    exp_resp = modelResp(addr);
    @(negedge clk);
    s_axil_wdata  = data;
    s_axil_wstrb  = strb;
    s_axil_wvalid = 1'b1;
    if (aw_delay == 0) begin
      s_axil_awaddr  = addr;
      s_axil_awvalid = 1'b1;
    end
    cyc = 0; last = 0; aw_done = 0; w_done = 0;
    while (!(aw_done && w_done) && cyc < 64) begin
      a_hs = s_axil_awvalid && s_axil_awready;
      w_hs = s_axil_wvalid && s_axil_wready;
      if (a_hs || w_hs) last = cyc;
      @(negedge clk);
      cyc++;
      if (a_hs) begin s_axil_awvalid = 1'b0; aw_done = 1; end
      if (w_hs) begin s_axil_wvalid = 1'b0; w_done = 1; end
      if (!aw_done && !s_axil_awvalid && cyc >= aw_delay) begin
        s_axil_awaddr  = addr;
        s_axil_awvalid = 1'b1;
      end
    end
    checkOutput({tag, "_accept"}, {30'd0, aw_done, w_done}, 32'd3);
    while (!s_axil_bvalid && cyc < last + 64) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, "_blat"}, 32'(cyc - last), 32'd2);
    checkOutput({tag, "_bresp"}, {30'd0, s_axil_bresp}, {30'd0, exp_resp});
    modelWrite(addr, data, strb);
  endtask

  // Full read transaction with latency and data check against the model
  task automatic readTxn(input logic [4:0] addr, input string tag);
    int cyc, hs;
    @(negedge clk);
    s_axil_araddr  = addr;
    s_axil_arvalid = 1'b1;
    cyc = 0;
    while (!s_axil_arready && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    hs = cyc;
    @(negedge clk);
    cyc++;
    s_axil_arvalid = 1'b0;
    while (!s_axil_rvalid && cyc < hs + 64) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, "_rlat"}, 32'(cyc - hs), 32'd1);
    checkOutput({tag, "_rdata"}, s_axil_rdata, modelRead(addr));
    checkOutput({tag, "_rresp"}, {30'd0, s_axil_rresp}, {30'd0, modelResp(addr)});
  endtask

  // Randomized mix of reads and writes across the whole address space
  task automatic applyStimulus(input int count);
    logic [4:0] addr;
    for (int n = 0; n < count; n++) begin
      addr = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1)
        writeTxn(addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), "rnd_wr");
      else
        readTxn(addr, "rnd_rd");
    end
  endtask

  // Main sequence
  initial begin
    rst = 1'b1;
    s_axil_awaddr = '0; s_axil_awprot = '0; s_axil_awvalid = 1'b0;
    s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0;
    s_axil_bready = 1'b1;
    s_axil_araddr = '0; s_axil_arprot = '0; s_axil_arvalid = 1'b0;
    s_axil_rready = 1'b0;
    for (int i = 0; i < NREG; i++) model_regs[i] = 32'd0;

    repeat (2) @(negedge clk);
    checkOutput("rst_awready", 32'(s_axil_awready), 32'd1);
    checkOutput("rst_wready", 32'(s_axil_wready), 32'd1);
    checkOutput("rst_arready", 32'(s_axil_arready), 32'd1);
    checkOutput("rst_bvalid", 32'(s_axil_bvalid), 32'd0);
    checkOutput("rst_bresp", {30'd0, s_axil_bresp}, 32'd0);
    checkOutput("rst_rvalid", 32'(s_axil_rvalid), 32'd0);
    checkOutput("rst_rdata", s_axil_rdata, 32'd0);
    checkOutput("rst_rresp", {30'd0, s_axil_rresp}, 32'd0);
    rst = 1'b0;
    s_axil_rready = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ready", {29'd0, s_axil_awready, s_axil_wready, s_axil_arready}, 32'd7);

    $display("[TB] simultaneous AW/W then readback");
    writeTxn(5'h04, 32'hDEADBEEF, 4'hF, 0, "w_sim");
    readTxn(5'h04, "r_sim");

    $display("[TB] W first, AW three cycles later, partial strobe");
    writeTxn(5'h08, 32'h12345678, 4'b0101, 3, "w_split");
    readTxn(5'h08, "r_split");
    checkOutput("split_literal", s_axil_rdata, 32'h00340078);

    $display("[TB] out-of-range write and read");
    writeTxn(5'h1C, 32'hCAFEF00D, 4'hF, 0, "w_oor");
    for (int i = 0; i < NREG; i++) readTxn(5'(i * 4), "r_after_oor");
    readTxn(5'h1C, "r_oor");

    $display("[TB] B back-pressure");
    s_axil_bready = 1'b0;
    writeTxn(5'h0C, 32'hA5A50001, 4'hF, 0, "w_bp1");
    s_axil_awaddr = 5'h18; s_axil_awvalid = 1'b1;
    s_axil_wdata = 32'hFFFFFFFF; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
    checkOutput("bp2_ready", {30'd0, s_axil_awready, s_axil_wready}, 32'd3);
    @(negedge clk);
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput("bp_stall_ready", {30'd0, s_axil_awready, s_axil_wready}, 32'd0);
      checkOutput("bp_stall_b", {29'd0, s_axil_bvalid, s_axil_bresp}, 32'd4);
      @(negedge clk);
    end
    s_axil_bready = 1'b1;
    @(negedge clk);
    checkOutput("bp2_b", {29'd0, s_axil_bvalid, s_axil_bresp}, 32'd6);
    checkOutput("bp2_ready_back", {30'd0, s_axil_awready, s_axil_wready}, 32'd3);
    @(negedge clk);
    checkOutput("bp_drained", 32'(s_axil_bvalid), 32'd0);
    modelWrite(5'h18, 32'hFFFFFFFF, 4'hF);
    readTxn(5'h0C, "r_bp1");

    $display("[TB] same-cycle read and write to word 0");
    writeTxn(5'h00, 32'h1, 4'hF, 0, "w_rw_old");
    @(negedge clk);
    s_axil_awaddr = 5'h00; s_axil_awvalid = 1'b1;
    s_axil_wdata = 32'h2; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
    @(negedge clk);
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    s_axil_araddr = 5'h00; s_axil_arvalid = 1'b1;
    @(negedge clk);
    s_axil_arvalid = 1'b0;
    checkOutput("rw_rvalid", 32'(s_axil_rvalid), 32'd1);
    checkOutput("rw_old_data", s_axil_rdata, 32'h1);
    checkOutput("rw_bvalid", 32'(s_axil_bvalid), 32'd1);
    modelWrite(5'h00, 32'h2, 4'hF);
    readTxn(5'h00, "rw_new");

    $display("[TB] randomized traffic");
    applyStimulus(120);

    $display("[TB] reset in the middle of a write");
    @(negedge clk);
    s_axil_awaddr = 5'h04; s_axil_awvalid = 1'b1;
    s_axil_wdata = 32'h55AA55AA; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
    @(negedge clk);
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("midrst_bvalid", 32'(s_axil_bvalid), 32'd0);
    checkOutput("midrst_ready", {30'd0, s_axil_awready, s_axil_wready}, 32'd3);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NREG; i++) model_regs[i] = 32'd0;
    repeat (2) @(negedge clk);
    checkOutput("midrst_no_b", 32'(s_axil_bvalid), 32'd0);
    for (int i = 0; i < NREG; i++) readTxn(5'(i * 4), "r_midrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
